// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the FIFO read controller, the 16x8 FIFO and the downstream stream sink.
// master = controller side, slave = the FIFO plus the downstream consumer.
interface fifo_rd_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_rd_enb;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready,
        output fifo_rd_enb,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output m_ready,
        input  fifo_rd_enb,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Consumer-side read controller: issues FIFO reads, captures returned words into a 2-entry skid buffer
// and presents them on a valid/ready stream. Optional FIFO_RD_CNT_EN adds a 16-bit pop counter (rd_count).
module fifo_rd_ctrl #(
    parameter int WIDTH = 8,
    parameter int SKID  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    fifo_rd_ctrl_if.master bus
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]    rd_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } count_e;

    count_e           count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             pop;
    logic             rd_enb;
    logic [2:0]       occupancy;

    assign pop = m_valid_q & bus.m_ready;

    // Slots committed after this edge: buffered words plus the word on the bus, minus the one leaving.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_enb    = ~reset & enable & ~bus.fifo_empty & (occupancy < 3'(SKID));

    assign bus.fifo_rd_enb = rd_enb;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = entry0_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path through the case infers a latch.
        count_d    = count_q;
        entry0_d   = entry0_q;
        entry1_d   = entry1_q;
        inflight_d = rd_enb;

        unique case (count_q)
            EMPTY: begin
                if (inflight_q) begin
                    entry0_d = bus.fifo_data_out;
                    count_d  = ONE;
                end
            end
            ONE: begin
                if (pop && inflight_q) begin
                    entry0_d = bus.fifo_data_out;
                end else if (pop) begin
                    count_d = EMPTY;
                end else if (inflight_q) begin
                    entry1_d = bus.fifo_data_out;
                    count_d  = TWO;
                end
            end
            TWO: begin
                if (pop) begin
                    entry0_d = entry1_q;
                    count_d  = ONE;
                    if (inflight_q) begin
                        entry1_d = bus.fifo_data_out;
                        count_d  = TWO;
                    end
                end
            end
            default: count_d = EMPTY;
        endcase

        m_valid_d = (count_d != EMPTY);
    end

    // NOTE: the data entries are reset too, because m_data must read 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= EMPTY;
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
            entry0_q   <= '0;
            entry1_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values regardless of order.
            count_q    <= count_d;
            inflight_q <= inflight_d;
            m_valid_q  <= m_valid_d;
            entry0_q   <= entry0_d;
            entry1_q   <= entry1_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

    // The issue rule keeps a returning word from ever meeting a full buffer.
    capture_in_two_a : assert property (@(posedge clk) disable iff (reset)
        !(inflight_q && count_q == TWO));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a 16x8 FIFO model feeds the DUT while a queue-based
// reference model predicts rd_enb / m_valid / m_data every cycle; directed phases pin literal values.
module tb_fifo_rd_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic wr_en;
    logic [WIDTH-1:0] wr_data;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH)) ifc ();

`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_rd_ctrl #(.WIDTH(WIDTH), .SKID(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bus     (ifc)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count(rd_count)
`endif
    );

    always #5 clk = ~clk;

    // 16x8 synchronous FIFO: read data appears the cycle after rd_enb is sampled.
    logic [WIDTH-1:0] fmem [16];
    int fwr = 0;
    int frd = 0;
    int fcnt = 0;

    assign ifc.fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        int n;
        n = fcnt;
        if (ifc.fifo_rd_enb && fcnt > 0) begin
            ifc.fifo_data_out <= fmem[frd];
            frd <= (frd + 1) % 16;
            n = n - 1;
        end
        if (wr_en && fcnt < 16) begin
            fmem[fwr] <= wr_data;
            fwr <= (fwr + 1) % 16;
            n = n + 1;
        end
        fcnt <= n;
    end

    int checks = 0;
    int failures = 0;

    // Reference model: words held downstream, plus a flag for a word returning from the FIFO.
    logic [WIDTH-1:0] mq[$];
    bit infl = 1'b0;
    int pops = 0;
    bit exp_rd, exp_pop;

    int cyc = 0;
    int rd_cyc[$];
    int val_cyc[$];
    int got_cyc[$];
    logic [WIDTH-1:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        infl = 1'b0;
        pops = 0;
    endtask

    task automatic compare_cycle();
        int held;
        int occ;
        held    = mq.size();
        exp_pop = !reset && (held != 0) && ifc.m_ready;
        occ     = held + int'(infl) - int'(exp_pop);
        exp_rd  = !reset && enable && !ifc.fifo_empty && (occ < 2);
        check("rd_enb", ifc.fifo_rd_enb, exp_rd);
        check("m_valid", ifc.m_valid, held != 0);
        if (held != 0) check("m_data", ifc.m_data, mq[0]);
        check("rd_while_empty", ifc.fifo_rd_enb & ifc.fifo_empty, 0);
`ifdef FIFO_RD_CNT_EN
        check("rd_count", rd_count, pops % 65536);
`endif
        cyc++;
        if (ifc.fifo_rd_enb) rd_cyc.push_back(cyc);
        if (ifc.m_valid) val_cyc.push_back(cyc);
        if (ifc.m_valid && ifc.m_ready) begin
            got.push_back(ifc.m_data);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            model_clear();
        end else begin
            if (exp_pop) begin
                void'(mq.pop_front());
                pops++;
            end
            if (infl) mq.push_back(ifc.fifo_data_out);
            infl = exp_rd;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic preload();
        enable = 1'b0;
        wr_en  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_data = WIDTH'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        enable = 1'b1;
        ifc.m_ready = 1'b1;
        while ((!ifc.fifo_empty || ifc.m_valid) && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_drained"}, {ifc.fifo_empty, ifc.m_valid}, 2'b10);
    endtask

    task automatic wait_first_rd(input string name, input int base_rd);
        int n;
        n = 0;
        while (rd_cyc.size() == base_rd && n < 20) begin
            tick();
            n++;
        end
        check({name, "_first_rd_seen"}, rd_cyc.size() > base_rd, 1);
    endtask

    task automatic check_words(input string name, input int base_g, input int first, input int count);
        check({name, "_word_count"}, got.size() - base_g, count);
        for (int k = 0; k < count; k++) begin
            if (base_g + k < got.size()) check({name, "_word"}, got[base_g + k], first + k);
        end
    endtask

    initial begin
        int base_rd, base_v, base_g;
        reset = 1'b1;
        enable = 1'b0;
        ifc.m_ready = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        repeat (2) tick();
        check("reset_rd_enb", ifc.fifo_rd_enb, 0);
        check("reset_m_valid", ifc.m_valid, 0);
        check("reset_m_data", ifc.m_data, 0);
`ifdef FIFO_RD_CNT_EN
        check("reset_rd_count", rd_count, 0);
`endif
        reset = 1'b0;

        // Idle with an empty FIFO: nothing may be read.
        enable = 1'b1;
        ifc.m_ready = 1'b1;
        base_rd = rd_cyc.size();
        repeat (12) tick();
        check("idle_rd_pulses", rd_cyc.size() - base_rd, 0);
        check("idle_m_valid", ifc.m_valid, 0);
        check("idle_m_data", ifc.m_data, 0);

        // Full-rate drain of 16 preloaded words.
        preload();
        base_rd = rd_cyc.size();
        base_v = val_cyc.size();
        base_g = got.size();
        enable = 1'b1;
        ifc.m_ready = 1'b1;
        repeat (24) tick();
        check("stream_rd_pulses", rd_cyc.size() - base_rd, 16);
        check("stream_valid_cycles", val_cyc.size() - base_v, 16);
        if (rd_cyc.size() - base_rd == 16)
            check("stream_rd_consecutive", rd_cyc[base_rd + 15] - rd_cyc[base_rd], 15);
        if (val_cyc.size() - base_v == 16 && rd_cyc.size() > base_rd) begin
            check("stream_latency", val_cyc[base_v] - rd_cyc[base_rd], 2);
            check("stream_valid_consecutive", val_cyc[base_v + 15] - val_cyc[base_v], 15);
        end
        check_words("stream", base_g, 1, 16);
`ifdef FIFO_RD_CNT_EN
        check("rd_count_after_drain", rd_count, 16);
`endif

        // Backpressure: two reads fill the skid buffer, then a gapless release.
        preload();
        base_rd = rd_cyc.size();
        enable = 1'b1;
        ifc.m_ready = 1'b0;
        repeat (10) tick();
        check("stall_rd_pulses", rd_cyc.size() - base_rd, 2);
        check("stall_m_valid", ifc.m_valid, 1);
        check("stall_m_data_held", ifc.m_data, 8'h01);
        base_g = got.size();
        ifc.m_ready = 1'b1;
        repeat (24) tick();
        check_words("release", base_g, 1, 16);
        if (got.size() - base_g == 16)
            check("release_no_gaps", got_cyc[base_g + 15] - got_cyc[base_g], 15);

        // Alternating ready.
        preload();
        base_g = got.size();
        enable = 1'b1;
        for (int i = 0; i < 48; i++) begin
            ifc.m_ready = (i % 2 == 0);
            tick();
        end
        check_words("toggle", base_g, 1, 16);
        drain("toggle");

        // Enable falls after the second read is issued.
        preload();
        base_rd = rd_cyc.size();
        base_g = got.size();
        ifc.m_ready = 1'b1;
        enable = 1'b1;
        wait_first_rd("en_drop", base_rd);
        tick();
        enable = 1'b0;
        base_rd = rd_cyc.size();
        repeat (10) tick();
        check("en_low_rd_pulses", rd_cyc.size() - base_rd, 0);
        check_words("en_low", base_g, 1, 2);
        enable = 1'b1;
        repeat (24) tick();
        check_words("en_back", base_g, 1, 16);

        // Async reset with one word buffered and one in flight: both are lost.
        preload();
        base_rd = rd_cyc.size();
        ifc.m_ready = 1'b0;
        enable = 1'b1;
        wait_first_rd("mid_reset", base_rd);
        tick();
        reset = 1'b1;
        model_clear();
        #1;
        check("async_reset_m_valid", ifc.m_valid, 0);
        check("async_reset_rd_enb", ifc.fifo_rd_enb, 0);
`ifdef FIFO_RD_CNT_EN
        check("async_reset_rd_count", rd_count, 0);
`endif
        repeat (2) tick();
        reset = 1'b0;
        ifc.m_ready = 1'b1;
        base_g = got.size();
        repeat (24) tick();
        check_words("after_reset", base_g, 3, 14);

        // Randomized traffic, with occasional reset pulses.
        drain("pre_random");
        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(0, 99) < 55);
            wr_data = WIDTH'($urandom);
            ifc.m_ready = ($urandom_range(0, 99) < 70);
            enable = ($urandom_range(0, 99) < 90);
            reset = ($urandom_range(0, 399) == 0);
            if (reset) model_clear();
            tick();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
